// File: rtl/lsu_mem_master_if.sv
// Core-side request/response and data-memory bus of the load/store unit.
// The master modport is the LSU itself; slave is the core plus memory environment.
interface lsu_mem_master_if;
  logic        req;
  logic        ready;
  logic        we;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        mem_we;
  logic [3:0]  mem_i;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (
    input  req, we, size, addr, wdata, mem_rd,
    output ready, rvalid, rdata, err, mem_we, mem_i, mem_a, mem_wd
  );

  modport slave (
    output req, we, size, addr, wdata, mem_rd,
    input  ready, rvalid, rdata, err, mem_we, mem_i, mem_a, mem_wd
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store unit: turns one byte/half/word access into one or two word accesses,
// splitting word-crossing misaligned accesses and extending load data.
module lsu_mem_master #(
  parameter int BYTE_OFF_W = 2
) (
  input  logic clk,
  input  logic rst,
  lsu_mem_master_if.master bus
);
  localparam int WW = 32 - BYTE_OFF_W;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t      state, state_nxt;
  logic        we_q, err_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q, wdata_q, lo, hi;

  logic          illegal;
  logic [2:0]    nbytes;
  logic [1:0]    o;
  logic [7:0]    mask8;
  logic          split;
  logic [4:0]    sh_lo, sh_hi;
  logic [WW-1:0] widx, widx1;
  logic [63:0]   t;
  logic [31:0]   ld_data;

  // Unsigned codes have no store form, so they are rejected when we=1.
  assign illegal = (bus.size == 3'b011) || (bus.size[2:1] == 2'b11) ||
                   (bus.size[2] && bus.we);

  always_comb begin
    case (size_q[1:0])
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  assign o     = addr_q[1:0];
  assign mask8 = ((8'd1 << nbytes) - 8'd1) << o;
  assign split = ({1'b0, o} + nbytes) > 3'd4;
  assign sh_lo = {o, 3'b000};
  // Only used on split accesses, where o is nonzero and 32-8*o fits in 5 bits.
  assign sh_hi = 5'(6'd32 - {1'b0, o, 3'b000});
  assign widx  = addr_q[31:BYTE_OFF_W];
  assign widx1 = widx + WW'(1);
  assign t     = {hi, lo} >> sh_lo;

  always_comb begin
    case (size_q)
      3'b000:  ld_data = {{24{t[7]}}, t[7:0]};
      3'b001:  ld_data = {{16{t[15]}}, t[15:0]};
      3'b010:  ld_data = t[31:0];
      3'b100:  ld_data = {24'd0, t[7:0]};
      3'b101:  ld_data = {16'd0, t[15:0]};
      default: ld_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      lo      <= 32'd0;
      hi      <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.req) begin
        we_q    <= bus.we;
        err_q   <= illegal;
        size_q  <= bus.size;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (state == ACC0 && !we_q) lo <= bus.mem_rd;
      if (state == ACC1 && !we_q) hi <= bus.mem_rd;
    end
  end

  always_comb begin
    state_nxt   = state;
    bus.ready   = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = 32'd0;
    bus.err     = 1'b0;
    bus.mem_we  = 1'b0;
    bus.mem_i   = 4'd0;
    bus.mem_a   = 32'd0;
    bus.mem_wd  = 32'd0;
    case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.req) state_nxt = illegal ? DONE : ACC0;
      end
      ACC0: begin
        bus.mem_a = 32'(widx);
        bus.mem_i = mask8[3:0];
        if (we_q) begin
          bus.mem_we = 1'b1;
          bus.mem_wd = wdata_q << sh_lo;
        end
        state_nxt = split ? ACC1 : DONE;
      end
      ACC1: begin
        bus.mem_a = 32'(widx1);
        bus.mem_i = mask8[7:4];
        if (we_q) begin
          bus.mem_we = 1'b1;
          bus.mem_wd = wdata_q >> sh_hi;
        end
        state_nxt = DONE;
      end
      DONE: begin
        bus.rvalid = 1'b1;
        bus.err    = err_q;
        if (!we_q && !err_q) bus.rdata = ld_data;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a 16-word byte-lane memory model.
module tb_lsu_mem_master;
  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  logic [31:0] mem [16];
  int n_chk = 0;
  int n_fail = 0;

  lsu_mem_master_if bus ();
  lsu_mem_master dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  assign bus.mem_rd = bus.mem_we ? 32'd0 : mem[bus.mem_a[3:0]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
    end else if (bus.mem_we) begin
      for (int k = 0; k < 4; k++)
        if (bus.mem_i[k]) mem[bus.mem_a[3:0]][8*k +: 8] <= bus.mem_wd[8*k +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge following acceptance.
  task automatic op(input logic w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
    chk("ready_idle", 32'(bus.ready), 32'd1);
    bus.req = 1'b1; bus.we = w; bus.size = s; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic done(input string tag, input logic [31:0] rd, input logic e);
    chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    chk({tag, "_rdata"}, bus.rdata, rd);
    chk({tag, "_err"}, 32'(bus.err), 32'(e));
    chk({tag, "_mem_i_idle"}, 32'(bus.mem_i), 32'd0);
    chk({tag, "_mem_we_idle"}, 32'(bus.mem_we), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 3'd0; bus.addr = 32'd0; bus.wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_i", 32'(bus.mem_i), 32'd0);
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_mem_wd", bus.mem_wd, 32'd0);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);

    op(1'b1, 3'b010, 32'h14, 32'hDEADBEEF);
    chk("sw14_a", bus.mem_a, 32'd5);
    chk("sw14_i", 32'(bus.mem_i), 32'hF);
    chk("sw14_we", 32'(bus.mem_we), 32'd1);
    chk("sw14_wd", bus.mem_wd, 32'hDEADBEEF);
    chk("sw14_busy", 32'(bus.ready), 32'd0);
    @(negedge clk); done("sw14", 32'd0, 1'b0);

    op(1'b0, 3'b010, 32'h14, 32'd0);
    chk("lw14_a", bus.mem_a, 32'd5);
    chk("lw14_i", 32'(bus.mem_i), 32'hF);
    chk("lw14_we", 32'(bus.mem_we), 32'd0);
    chk("lw14_wd", bus.mem_wd, 32'd0);
    @(negedge clk); done("lw14", 32'hDEADBEEF, 1'b0);

    op(1'b1, 3'b000, 32'h0B, 32'h000000F0);
    chk("sb0b_a", bus.mem_a, 32'd2);
    chk("sb0b_i", 32'(bus.mem_i), 32'h8);
    chk("sb0b_wd", bus.mem_wd, 32'hF0000000);
    @(negedge clk); done("sb0b", 32'd0, 1'b0);
    chk("sb0b_mem2", mem[2], 32'hF0000000);

    op(1'b0, 3'b000, 32'h0B, 32'd0);
    @(negedge clk); done("lb0b", 32'hFFFFFFF0, 1'b0);
    op(1'b0, 3'b100, 32'h0B, 32'd0);
    @(negedge clk); done("lbu0b", 32'h000000F0, 1'b0);

    op(1'b1, 3'b010, 32'h0E, 32'h11223344);
    chk("sw0e_a0", bus.mem_a, 32'd3);
    chk("sw0e_i0", 32'(bus.mem_i), 32'hC);
    chk("sw0e_wd0", bus.mem_wd, 32'h33440000);
    @(negedge clk);
    chk("sw0e_a1", bus.mem_a, 32'd4);
    chk("sw0e_i1", 32'(bus.mem_i), 32'h3);
    chk("sw0e_wd1", bus.mem_wd, 32'h00001122);
    chk("sw0e_we1", 32'(bus.mem_we), 32'd1);
    chk("sw0e_novalid", 32'(bus.rvalid), 32'd0);
    @(negedge clk); done("sw0e", 32'd0, 1'b0);

    op(1'b0, 3'b010, 32'h0E, 32'd0);
    @(negedge clk);
    chk("lw0e_novalid_t2", 32'(bus.rvalid), 32'd0);
    @(negedge clk); done("lw0e", 32'h11223344, 1'b0);

    op(1'b1, 3'b010, 32'h00, 32'h80000000); @(negedge clk); done("sw00", 32'd0, 1'b0);
    op(1'b1, 3'b010, 32'h04, 32'h00000001); @(negedge clk); done("sw04", 32'd0, 1'b0);

    op(1'b0, 3'b001, 32'h03, 32'd0);
    chk("lh03_i0", 32'(bus.mem_i), 32'h8);
    @(negedge clk);
    chk("lh03_a1", bus.mem_a, 32'd1);
    chk("lh03_i1", 32'(bus.mem_i), 32'h1);
    @(negedge clk); done("lh03a", 32'h00000180, 1'b0);

    op(1'b1, 3'b000, 32'h04, 32'h00000091);
    chk("sb04_i", 32'(bus.mem_i), 32'h1);
    @(negedge clk); done("sb04", 32'd0, 1'b0);
    op(1'b0, 3'b001, 32'h03, 32'd0); repeat (2) @(negedge clk); done("lh03b", 32'hFFFF9180, 1'b0);
    op(1'b0, 3'b101, 32'h03, 32'd0); repeat (2) @(negedge clk); done("lhu03", 32'h00009180, 1'b0);

    op(1'b0, 3'b001, 32'h02, 32'd0);
    chk("lh02_i", 32'(bus.mem_i), 32'hC);
    @(negedge clk); done("lh02", 32'hFFFF8000, 1'b0);

    op(1'b0, 3'b011, 32'h14, 32'd0);
    chk("ill_mem_i", 32'(bus.mem_i), 32'd0);
    chk("ill_mem_a", bus.mem_a, 32'd0);
    done("ill011", 32'd0, 1'b1);
    chk("ill_ready_back", 32'(bus.ready), 32'd1);
    chk("ill_rvalid_low", 32'(bus.rvalid), 32'd0);

    op(1'b1, 3'b101, 32'h14, 32'h12345678);
    chk("illst_mem_we", 32'(bus.mem_we), 32'd0);
    done("illst", 32'd0, 1'b1);

    op(1'b1, 3'b010, 32'h3C, 32'h55660000); @(negedge clk); done("sw3c", 32'd0, 1'b0);
    op(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0);
    chk("wrap_a0", bus.mem_a, 32'h3FFFFFFF);
    chk("wrap_i0", 32'(bus.mem_i), 32'hC);
    @(negedge clk);
    chk("wrap_a1", bus.mem_a, 32'd0);
    chk("wrap_i1", 32'(bus.mem_i), 32'h3);
    @(negedge clk); done("wrap", 32'h00005566, 1'b0);

    op(1'b1, 3'b010, 32'h0E, 32'hAABBCCDD);
    chk("rstmid_acc0_we", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_ready", 32'(bus.ready), 32'd1);
    chk("rstmid_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rstmid_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rstmid_mem_i", 32'(bus.mem_i), 32'd0);
    chk("rstmid_mem_a", bus.mem_a, 32'd0);
    chk("rstmid_mem_wd", bus.mem_wd, 32'd0);
    chk("rstmid_word4", mem[4], 32'h00001122);
    @(negedge clk);
    chk("rstmid_rvalid2", 32'(bus.rvalid), 32'd0);
    chk("rstmid_word4b", mem[4], 32'h00001122);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
